// File: rtl/pl_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pl_hazard_ctrl_pkg
// Shared types and constants for the pipeline hazard sequencer.
//   reg_addr_t   : 5-bit architectural register index
//   hz_state_t   : sequencer state, encoding RUN=0, LOAD=1, FLUSH=2, MEM=3
//   HZ_FLUSH_MAX : largest legal flush depth
//   HZ_CNT_W     : width of the flush counter (holds up to HZ_FLUSH_MAX)
// -----------------------------------------------------------------------------
package pl_hazard_ctrl_pkg;

    typedef logic [4:0] reg_addr_t;

    typedef enum logic [1:0] {
        HZ_RUN   = 2'd0,
        HZ_LOAD  = 2'd1,
        HZ_FLUSH = 2'd2,
        HZ_MEM   = 2'd3
    } hz_state_t;

    localparam int HZ_FLUSH_MAX = 7;
    localparam int HZ_CNT_W     = 3;

endpackage

// File: rtl/pl_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pl_hazard_ctrl_if
// Bundle between the pipeline stages and the hazard sequencer.
//   i_dec_*           : decode-stage source register fields and use flags
//   i_ex_*            : execute-stage load status, destination, taken branch
//   i_mem_busy        : data memory cannot complete this cycle
//   o_pc_stall .. o_mem_stall : pipeline control strobes
//   o_hz_state        : current sequencer state
// Modports: master = pipeline side, slave = hazard sequencer side.
// -----------------------------------------------------------------------------
interface pl_hazard_ctrl_if;
    import pl_hazard_ctrl_pkg::*;

    reg_addr_t i_dec_rs1_addr;
    reg_addr_t i_dec_rs2_addr;
    logic      i_dec_rs1_used;
    logic      i_dec_rs2_used;
    logic      i_ex_is_load;
    reg_addr_t i_ex_rd_addr;
    logic      i_ex_branch_taken;
    logic      i_mem_busy;

    logic      o_pc_stall;
    logic      o_dec_stall;
    logic      o_ex_bubble;
    logic      o_dec_flush;
    logic      o_mem_stall;
    hz_state_t o_hz_state;

    modport master (
        output i_dec_rs1_addr, i_dec_rs2_addr, i_dec_rs1_used, i_dec_rs2_used,
        output i_ex_is_load, i_ex_rd_addr, i_ex_branch_taken, i_mem_busy,
        input  o_pc_stall, o_dec_stall, o_ex_bubble, o_dec_flush, o_mem_stall,
        input  o_hz_state
    );

    modport slave (
        input  i_dec_rs1_addr, i_dec_rs2_addr, i_dec_rs1_used, i_dec_rs2_used,
        input  i_ex_is_load, i_ex_rd_addr, i_ex_branch_taken, i_mem_busy,
        output o_pc_stall, o_dec_stall, o_ex_bubble, o_dec_flush, o_mem_stall,
        output o_hz_state
    );

endinterface

// File: rtl/pl_hazard_ctrl_hz_detect.sv
// -----------------------------------------------------------------------------
// hz_detect
// Combinational load-use comparator. Flags when the decode instruction reads a
// register that the load in execute has not yet written. Register 0 is
// hard-wired, so a load targeting it never creates a dependency.
//   rs1_addr/rs2_addr : decode source fields
//   rs1_used/rs2_used : decode actually reads that source
//   ex_is_load        : execute holds a load
//   ex_rd_addr        : execute destination
//   load_use          : dependency present
// -----------------------------------------------------------------------------
module hz_detect
    import pl_hazard_ctrl_pkg::*;
(
    input  reg_addr_t rs1_addr,
    input  reg_addr_t rs2_addr,
    input  logic      rs1_used,
    input  logic      rs2_used,
    input  logic      ex_is_load,
    input  reg_addr_t ex_rd_addr,
    output logic      load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = rs1_used && (rs1_addr == ex_rd_addr);
    assign rs2_hit  = rs2_used && (rs2_addr == ex_rd_addr);
    assign load_use = ex_is_load && (ex_rd_addr != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pl_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pl_hazard_ctrl
// Central hazard sequencer for the 5-stage core. Arbitrates memory wait,
// taken branch and load-use events (in that priority) and drives the stall,
// bubble and flush controls with zero-cycle (Mealy) latency.
// Parameters:
//   FLUSH_DEPTH : cycles o_dec_flush stays high after a taken branch (1..7)
//   PERF_CNT_W  : width of the optional performance counters
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   hz           : pl_hazard_ctrl_if.slave (pipeline inputs, control outputs)
//   o_stall_cycles, o_flush_cycles : saturating cycle counters, only present
//                 when HZ_PERF_CNT_EN is defined
// -----------------------------------------------------------------------------
module pl_hazard_ctrl
    import pl_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_DEPTH = 2,
    parameter int PERF_CNT_W  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    pl_hazard_ctrl_if.slave       hz
`ifdef HZ_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] o_stall_cycles,
    output logic [PERF_CNT_W-1:0] o_flush_cycles
`endif
);

    localparam logic [HZ_CNT_W-1:0] CNT_RELOAD  = HZ_CNT_W'(FLUSH_DEPTH - 1);
    localparam hz_state_t           BRANCH_NEXT = (FLUSH_DEPTH > 1) ? HZ_FLUSH : HZ_RUN;

    hz_state_t           state_q, state_d;
    hz_state_t           saved_q, saved_d;
    hz_state_t           eval_state;
    logic [HZ_CNT_W-1:0] cnt_q, cnt_d;
    logic                load_use;
    logic                pc_stall, dec_stall, ex_bubble, dec_flush, mem_stall;

    hz_detect u_detect (
        .rs1_addr   (hz.i_dec_rs1_addr),
        .rs2_addr   (hz.i_dec_rs2_addr),
        .rs1_used   (hz.i_dec_rs1_used),
        .rs2_used   (hz.i_dec_rs2_used),
        .ex_is_load (hz.i_ex_is_load),
        .ex_rd_addr (hz.i_ex_rd_addr),
        .load_use   (load_use)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the priority chain can leave one unassigned (no latch).
        state_d   = state_q;
        saved_d   = saved_q;
        cnt_d     = cnt_q;
        pc_stall  = 1'b0;
        dec_stall = 1'b0;
        ex_bubble = 1'b0;
        dec_flush = 1'b0;
        mem_stall = 1'b0;

        // Leaving a memory wait resumes the saved state's rules in the same
        // cycle, so the release cycle is not lost.
        eval_state = (state_q == HZ_MEM && !hz.i_mem_busy) ? saved_q : state_q;

        if (eval_state == HZ_MEM) begin
            // Still waiting: branch and load-use are ignored until release.
            mem_stall = 1'b1;
            pc_stall  = 1'b1;
            dec_stall = 1'b1;
        end else if (hz.i_mem_busy) begin
            // A pending flush is resumed after the wait; LOAD's guard is not.
            mem_stall = 1'b1;
            pc_stall  = 1'b1;
            dec_stall = 1'b1;
            saved_d   = (eval_state == HZ_FLUSH) ? HZ_FLUSH : HZ_RUN;
            state_d   = HZ_MEM;
        end else if (hz.i_ex_branch_taken) begin
            dec_flush = 1'b1;
            ex_bubble = 1'b1;
            cnt_d     = CNT_RELOAD;
            state_d   = BRANCH_NEXT;
        end else if (eval_state == HZ_FLUSH) begin
            // Decode content is discarded, so load-use is irrelevant here.
            dec_flush = 1'b1;
            cnt_d     = cnt_q - 1'b1;
            state_d   = (cnt_q == HZ_CNT_W'(1)) ? HZ_RUN : HZ_FLUSH;
        end else if (eval_state == HZ_RUN && load_use) begin
            pc_stall  = 1'b1;
            dec_stall = 1'b1;
            ex_bubble = 1'b1;
            state_d   = HZ_LOAD;
        end else begin
            state_d   = HZ_RUN;
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: reset is sampled on the clock edge, and all state is updated
        // with non-blocking assignments so every register sees pre-edge values.
        if (i_rst) begin
            state_q <= HZ_RUN;
            saved_q <= HZ_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are forced low for the whole reset cycle, whatever the inputs.
    assign hz.o_pc_stall  = pc_stall  & ~i_rst;
    assign hz.o_dec_stall = dec_stall & ~i_rst;
    assign hz.o_ex_bubble = ex_bubble & ~i_rst;
    assign hz.o_dec_flush = dec_flush & ~i_rst;
    assign hz.o_mem_stall = mem_stall & ~i_rst;
    assign hz.o_hz_state  = i_rst ? HZ_RUN : state_q;

`ifdef HZ_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] stall_cnt_q;
    logic [PERF_CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (pc_stall && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + PERF_CNT_W'(1);
            end
            if (dec_flush && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + PERF_CNT_W'(1);
            end
        end
    end

    assign o_stall_cycles = i_rst ? '0 : stall_cnt_q;
    assign o_flush_cycles = i_rst ? '0 : flush_cnt_q;
`endif

endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pl_hazard_ctrl
// Drives two sequencers (FLUSH_DEPTH=2 and FLUSH_DEPTH=1) with the same
// stimulus and compares them every cycle against a behavioural model that
// tracks "remaining flush cycles", "waiting on memory" and "load guard".
// With HZ_PERF_CNT_EN defined the performance counters are checked as well.
// -----------------------------------------------------------------------------
module tb_pl_hazard_ctrl;
    import pl_hazard_ctrl_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       t_busy, t_br, t_ld, t_u1, t_u2;
    logic [4:0] t_rd, t_rs1, t_rs2;

    int checks   = 0;
    int failures = 0;

    // Reference model state, one entry per DUT.
    int depth [2] = '{2, 1};
    int flush_left [2];
    bit waiting [2];
    bit guard [2];

    always #5 i_clk = ~i_clk;

    pl_hazard_ctrl_if bus_a ();
    pl_hazard_ctrl_if bus_b ();

`ifdef HZ_PERF_CNT_EN
    logic [31:0] stall_a, flush_a, stall_b, flush_b;
    int stall_tot = 0;
    int flush_tot = 0;
`endif

    pl_hazard_ctrl #(.FLUSH_DEPTH(2), .PERF_CNT_W(32)) dut_a (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .hz    (bus_a.slave)
`ifdef HZ_PERF_CNT_EN
        ,
        .o_stall_cycles (stall_a),
        .o_flush_cycles (flush_a)
`endif
    );

    pl_hazard_ctrl #(.FLUSH_DEPTH(1), .PERF_CNT_W(32)) dut_b (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .hz    (bus_b.slave)
`ifdef HZ_PERF_CNT_EN
        ,
        .o_stall_cycles (stall_b),
        .o_flush_cycles (flush_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic rst, input logic busy, input logic br, input logic ld,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2);
        i_rst = rst; t_busy = busy; t_br = br; t_ld = ld;
        t_rd = rd; t_rs1 = rs1; t_rs2 = rs2; t_u1 = u1; t_u2 = u2;
        bus_a.i_mem_busy = busy;  bus_b.i_mem_busy = busy;
        bus_a.i_ex_branch_taken = br; bus_b.i_ex_branch_taken = br;
        bus_a.i_ex_is_load = ld;  bus_b.i_ex_is_load = ld;
        bus_a.i_ex_rd_addr = rd;  bus_b.i_ex_rd_addr = rd;
        bus_a.i_dec_rs1_addr = rs1; bus_b.i_dec_rs1_addr = rs1;
        bus_a.i_dec_rs2_addr = rs2; bus_b.i_dec_rs2_addr = rs2;
        bus_a.i_dec_rs1_used = u1;  bus_b.i_dec_rs1_used = u1;
        bus_a.i_dec_rs2_used = u2;  bus_b.i_dec_rs2_used = u2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
            step();
        end
    endtask

    // Checks one cycle (inputs already applied), advances the model, and
    // waits for the next falling edge.
    task automatic step();
        logic        lu;
        logic [31:0] obs [6];
        logic [31:0] exp [6];
        string       fld [6] = '{"pc_stall", "dec_stall", "ex_bubble", "dec_flush", "mem_stall", "hz_state"};
        #1;
        lu = t_ld && (t_rd != 5'd0) && ((t_u1 && t_rs1 == t_rd) || (t_u2 && t_rs2 == t_rd));
        for (int k = 0; k < 2; k++) begin
            for (int f = 0; f < 6; f++) exp[f] = '0;
            if (!i_rst) begin
                exp[5] = waiting[k] ? 3 : (flush_left[k] > 0) ? 2 : guard[k] ? 1 : 0;
                if (t_busy) begin
                    exp[0] = 1; exp[1] = 1; exp[4] = 1;
                end else if (t_br) begin
                    exp[2] = 1; exp[3] = 1;
                end else if (flush_left[k] > 0) begin
                    exp[3] = 1;
                end else if (lu && !guard[k]) begin
                    exp[0] = 1; exp[1] = 1; exp[2] = 1;
                end
            end
            if (k == 0) begin
                obs[0] = 32'(bus_a.o_pc_stall);  obs[1] = 32'(bus_a.o_dec_stall);
                obs[2] = 32'(bus_a.o_ex_bubble); obs[3] = 32'(bus_a.o_dec_flush);
                obs[4] = 32'(bus_a.o_mem_stall); obs[5] = 32'(bus_a.o_hz_state);
            end else begin
                obs[0] = 32'(bus_b.o_pc_stall);  obs[1] = 32'(bus_b.o_dec_stall);
                obs[2] = 32'(bus_b.o_ex_bubble); obs[3] = 32'(bus_b.o_dec_flush);
                obs[4] = 32'(bus_b.o_mem_stall); obs[5] = 32'(bus_b.o_hz_state);
            end
            for (int f = 0; f < 6; f++) begin
                check($sformatf("d%0d_%s t=%0t", depth[k], fld[f], $time), obs[f], exp[f]);
            end
`ifdef HZ_PERF_CNT_EN
            if (k == 0) begin
                check($sformatf("stall_cycles t=%0t", $time), stall_a, i_rst ? 0 : 32'(stall_tot));
                check($sformatf("flush_cycles t=%0t", $time), flush_a, i_rst ? 0 : 32'(flush_tot));
                if (i_rst) begin
                    stall_tot = 0; flush_tot = 0;
                end else begin
                    stall_tot += int'(exp[0]); flush_tot += int'(exp[3]);
                end
            end
`endif
            // Model update.
            if (i_rst) begin
                flush_left[k] = 0; waiting[k] = 0; guard[k] = 0;
            end else if (t_busy) begin
                waiting[k] = 1; guard[k] = 0;
            end else begin
                waiting[k] = 0;
                if (t_br) begin
                    flush_left[k] = depth[k] - 1; guard[k] = 0;
                end else if (flush_left[k] > 0) begin
                    flush_left[k]--; guard[k] = 0;
                end else begin
                    guard[k] = lu && !guard[k];
                end
            end
        end
        @(negedge i_clk);
    endtask

    initial begin
        // Reset with busy/branch active: outputs must still read zero.
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        step();
        idle(1);

        // Load-use on rs2, held for the guard cycle, then released.
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1);
        step();
        step();
        idle(1);
        // Load to x0 never stalls.
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        step();
        // rs1 match but rs1 unused: no stall.
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd3, 1'b0, 1'b1);
        step();

        // Single taken branch.
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        idle(3);

        // Branch together with load-use: branch wins.
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0);
        step();
        idle(3);

        // Memory wait of 3 cycles while in FLUSH with one flush cycle left.
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
            step();
        end
        idle(2);

        // Busy and branch together, then the branch re-presented.
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        idle(3);

        // Reset in MEM, then reset in FLUSH.
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        idle(2);
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        idle(2);

        // Randomized traffic with small register indices to force matches.
        for (int n = 0; n < 600; n++) begin
            set_in($urandom_range(0, 99) < 2,
                   $urandom_range(0, 99) < 20,
                   $urandom_range(0, 99) < 15,
                   $urandom_range(0, 99) < 50,
                   5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
